// File: rtl/csum_insert_pkg.sv
// Shared types for the checksum insert block: FSM state encoding, checksum lane
// selectors, the stream beat payload and the checksum patch helper.
package csum_insert_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CSUM_W = 16;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Replace one 16-bit half of a word with the checksum; the other half is kept.
  function automatic logic [DATA_W-1:0] patch_word(input logic [DATA_W-1:0] w,
                                                   input logic [CSUM_W-1:0] c,
                                                   input logic              lane);
    logic [DATA_W-1:0] r;
    r = w;
    if (lane == LANE_HI) r[31:16] = c;
    else                 r[15:0]  = c;
    return r;
  endfunction

endpackage

// File: rtl/csum_insert_if.sv
// Packet stream interface: beat (data/sop/eop), valid, ready.
//   master: drives beat and valid, receives ready
//   slave : receives beat and valid, drives ready
interface csum_insert_if;
  import csum_insert_pkg::*;

  beat_t beat;
  logic  valid;
  logic  ready;

  modport master (output beat, output valid, input ready);
  modport slave  (input beat, input valid, output ready);

endinterface

// File: rtl/csum_buf_ram.sv
// Simple dual-port packet buffer, one write port and one registered read port.
//   clk                      : clock
//   wr_en / wr_addr / wr_data: write port
//   rd_en / rd_addr          : read request, data valid on rd_data next cycle
module csum_buf_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/csum_insert.sv
// Buffers one packet while the upstream calculator sums it, then replays it with
// the checksum written into a fixed header word.
//   clk, rst          : clock, synchronous active-high reset
//   s (slave)         : ingress stream, shared with the checksum calculator
//   m (master)        : egress stream with patched header word
//   csum_in, csum_rdy : checksum and its one-cycle valid pulse
//   err_ovf, err_tmo  : one-cycle drop pulses (buffer overflow, checksum timeout)
// Optional: define CSUM_INSERT_STATS_EN to add pkt_cnt / drop_cnt counters.
module csum_insert
  import csum_insert_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned CSUM_WORD  = 2,
  parameter int unsigned CSUM_LANE  = 0,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  csum_insert_if.slave      s,
  csum_insert_if.master     m,
  input  logic [CSUM_W-1:0] csum_in,
  input  logic              csum_rdy,
  output logic              err_ovf,
  output logic              err_tmo
`ifdef CSUM_INSERT_STATS_EN
  ,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(1) << DEPTH_LOG2;

  state_t              state;
  logic                s_ready_q;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_idx;
  logic                drop;
  logic [TMR_W-1:0]    tmr;
  logic [CSUM_W-1:0]   csum_q;
  logic                rd_vld;
  logic                out_vld;
  logic                skid_vld;
  beat_t               out_q;
  beat_t               skid_q;

  logic                s_fire_c;
  logic                full_c;
  logic                wr_en_c;
  logic [DEPTH_LOG2-1:0] wr_addr_c;
  logic                rd_en_c;
  logic                out_fire_c;
  logic [DATA_W-1:0]   ram_rd_data;
  beat_t               rd_beat_c;

  assign s.ready = s_ready_q;
  assign m.valid = out_vld;
  assign m.beat  = out_q;

  assign s_fire_c   = s.valid & s_ready_q;
  assign full_c     = (wr_ptr == FULL_CNT);
  assign out_fire_c = out_vld & m.ready;

  // Only store words that belong to a live, non-overflowed packet; sop restarts at 0.
  assign wr_en_c = s_fire_c &&
                   (((state == IDLE) && s.beat.sop) ||
                    ((state == FILL) && (s.beat.sop || (!drop && !full_c))));
  assign wr_addr_c = s.beat.sop ? '0 : wr_ptr[DEPTH_LOG2-1:0];

  // Issue a read only if the returning word is guaranteed a slot in out_q or skid_q.
  assign rd_en_c = (state == DRAIN) && (rd_ptr != wr_ptr) && !skid_vld &&
                   !(rd_vld && out_vld && !m.ready);

  csum_buf_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (s.beat.data),
    .rd_en   (rd_en_c),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (ram_rd_data)
  );

  // Patch mux and framing for the word coming out of the RAM.
  always_comb begin
    rd_beat_c.data = ram_rd_data;
    if (rd_idx == PTR_W'(CSUM_WORD)) rd_beat_c.data = patch_word(ram_rd_data, csum_q, 1'(CSUM_LANE));
    rd_beat_c.sop = (rd_idx == '0);
    rd_beat_c.eop = (rd_idx == (wr_ptr - PTR_W'(1)));
  end

  // Control FSM, checksum timer and egress output/skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_ready_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_idx    <= '0;
      drop      <= 1'b0;
      tmr       <= '0;
      csum_q    <= '0;
      rd_vld    <= 1'b0;
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
      err_ovf   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
      rd_vld  <= rd_en_c;
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        rd_idx <= rd_ptr;
      end

      case (state)
        IDLE: begin
          if (s_fire_c && s.beat.sop) begin
            wr_ptr <= PTR_W'(1);
            drop   <= 1'b0;
            if (s.beat.eop) begin
              state     <= WAIT;
              s_ready_q <= 1'b0;
              tmr       <= '0;
            end else begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          if (s_fire_c) begin
            if (s.beat.sop) begin
              wr_ptr <= PTR_W'(1);
              drop   <= 1'b0;
            end else if (!drop && full_c) begin
              drop    <= 1'b1;
              err_ovf <= 1'b1;
            end else if (!drop) begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (s.beat.eop) begin
              state     <= WAIT;
              s_ready_q <= 1'b0;
              tmr       <= '0;
            end
          end
        end

        WAIT: begin
          if (csum_rdy) begin
            csum_q <= csum_in;
            rd_ptr <= '0;
            if (drop) begin
              state     <= IDLE;
              s_ready_q <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            err_tmo   <= 1'b1;
            state     <= IDLE;
            s_ready_q <= 1'b1;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        DRAIN: begin
          if (out_fire_c && out_q.eop) begin
            state     <= IDLE;
            s_ready_q <= 1'b1;
            out_vld   <= 1'b0;
            skid_vld  <= 1'b0;
          end else if (!out_vld || out_fire_c) begin
            // Output slot frees up: skid word goes first, then fresh RAM data.
            if (skid_vld) begin
              out_q    <= skid_q;
              out_vld  <= 1'b1;
              skid_q   <= rd_beat_c;
              skid_vld <= rd_vld;
            end else begin
              out_q   <= rd_beat_c;
              out_vld <= rd_vld;
            end
          end else if (rd_vld) begin
            skid_q   <= rd_beat_c;
            skid_vld <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef CSUM_INSERT_STATS_EN
  // Delivered-packet and dropped-packet counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_fire_c && out_q.eop) pkt_cnt <= pkt_cnt + 32'd1;
      if (err_ovf || err_tmo)      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
